// File: rtl/note_cmd_rx.sv
// Serial note-command receiver: 8N1 UART front end plus a MIDI Note On/Off parser that drives a
// 6-bit note index and a gate per synth channel. Optional macro NOTE_CMD_ALL_OFF_EN enables 0xBn
// with controller 123 (all notes off) per channel.
module note_cmd_rx #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 31250,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NOTE_BASE = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_in,
  output logic [6*NUM_CH-1:0] note_out,
  output logic [NUM_CH-1:0]   gate_out,
  output logic                msg_valid,
  output logic                frame_err
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned ChW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {UIdle, UStart, UData, UStop, UWaitHigh} uart_st_e;
  typedef enum logic [1:0] {PsWaitStatus, PsWaitKey, PsWaitVel} parse_st_e;
  typedef enum logic [1:0] {KindOn, KindOff, KindCc} kind_e;

  logic            rx_meta_q, rx_sync_q;
  uart_st_e        uart_st_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q, byte_q;
  logic            byte_stb_q, frame_err_q;

  // UART receiver; start/data/stop are all sampled mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      uart_st_q   <= UIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_in;
      rx_sync_q   <= rx_meta_q;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (uart_st_q)
        UIdle: begin
          cnt_q <= '0;
          if (!rx_sync_q) uart_st_q <= UStart;
        end
        UStart: begin
          if (cnt_q == CntW'(HalfBit - 1)) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            uart_st_q <= rx_sync_q ? UIdle : UData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        UData: begin
          if (cnt_q == CntW'(ClksPerBit - 1)) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) uart_st_q <= UStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        UStop: begin
          if (cnt_q == CntW'(ClksPerBit - 1)) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              byte_q     <= shift_q;
              byte_stb_q <= 1'b1;
              uart_st_q  <= UIdle;
            end else begin
              frame_err_q <= 1'b1;
              uart_st_q   <= UWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        UWaitHigh: if (rx_sync_q) uart_st_q <= UIdle;
        default:   uart_st_q <= UIdle;
      endcase
    end
  end

  parse_st_e           ps_st_q;
  logic                rs_valid_q;
  kind_e               rs_kind_q;
  logic [ChW-1:0]      rs_ch_q;
  logic [6:0]          key_q;
  logic [6*NUM_CH-1:0] note_q;
  logic [NUM_CH-1:0]   gate_q;
  logic                msg_valid_q;

  logic       is_rt, ch_ok, status_ok, key_ok;
  kind_e      status_kind;
  logic [7:0] key_ext, idx_full;
  logic [5:0] idx;

  assign is_rt    = (byte_q[7:3] == 5'b11111);
  assign ch_ok    = 32'(byte_q[3:0]) < NUM_CH;
  assign key_ext  = {1'b0, key_q};
  assign idx_full = key_ext - 8'(NOTE_BASE - 1);
  assign key_ok   = (32'(key_ext) >= NOTE_BASE) && (idx_full <= 8'd63);
  assign idx      = idx_full[5:0];

  always_comb begin
    status_ok   = 1'b0;
    status_kind = KindOn;
    if (ch_ok) begin
      case (byte_q[7:4])
        4'h9: begin status_ok = 1'b1; status_kind = KindOn;  end
        4'h8: begin status_ok = 1'b1; status_kind = KindOff; end
`ifdef NOTE_CMD_ALL_OFF_EN
        4'hB: begin status_ok = 1'b1; status_kind = KindCc;  end
`endif
        default: ;
      endcase
    end
  end

  // Message parser; results are registered one cycle after the velocity byte strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_st_q     <= PsWaitStatus;
      rs_valid_q  <= 1'b0;
      rs_kind_q   <= KindOn;
      rs_ch_q     <= '0;
      key_q       <= '0;
      note_q      <= '0;
      gate_q      <= '0;
      msg_valid_q <= 1'b0;
    end else begin
      msg_valid_q <= 1'b0;
      if (byte_stb_q && !is_rt) begin
        if (byte_q[7]) begin
          rs_valid_q <= status_ok;
          rs_kind_q  <= status_kind;
          rs_ch_q    <= ChW'(byte_q[3:0]);
          ps_st_q    <= status_ok ? PsWaitKey : PsWaitStatus;
        end else begin
          case (ps_st_q)
            PsWaitStatus: begin
              if (rs_valid_q) begin
                key_q   <= byte_q[6:0];
                ps_st_q <= PsWaitVel;
              end
            end
            PsWaitKey: begin
              key_q   <= byte_q[6:0];
              ps_st_q <= PsWaitVel;
            end
            PsWaitVel: begin
              ps_st_q <= PsWaitKey;
              for (int k = 0; k < NUM_CH; k++) begin
                if (ChW'(k) == rs_ch_q) begin
                  if (rs_kind_q != KindCc) begin
                    if (key_ok) begin
                      msg_valid_q <= 1'b1;
                      if (rs_kind_q == KindOn && byte_q[6:0] != 7'd0) begin
                        note_q[6*k +: 6] <= idx;
                        gate_q[k]        <= 1'b1;
                      end else if (note_q[6*k +: 6] == idx) begin
                        gate_q[k] <= 1'b0;
                      end
                    end
                  end
`ifdef NOTE_CMD_ALL_OFF_EN
                  else if (key_q == 7'd123) begin
                    gate_q[k]   <= 1'b0;
                    msg_valid_q <= 1'b1;
                  end
`endif
                end
              end
            end
            default: ps_st_q <= PsWaitStatus;
          endcase
        end
      end
    end
  end

  assign note_out  = note_q;
  assign gate_out  = gate_q;
  assign msg_valid = msg_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_note_cmd_rx.sv
// Directed bench for note_cmd_rx: table of MIDI byte sequences with expected outputs, plus
// hand-written frame-error, start-glitch and mid-message reset sequences.
module tb_note_cmd_rx;

  localparam int unsigned ClkHz = 160000;
  localparam int unsigned Baud  = 10000;
  localparam int unsigned Cpb   = 16;
  localparam int          NV    = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [23:0] note_out;
  logic [3:0]  gate_out;
  logic        msg_valid, frame_err;

  note_cmd_rx #(
    .CLK_HZ   (ClkHz),
    .BAUD     (Baud),
    .NUM_CH   (4),
    .NOTE_BASE(36)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx),
    .note_out (note_out),
    .gate_out (gate_out),
    .msg_valid(msg_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          n;
    logic [31:0] bytes;  // first byte in [31:24]
    logic [23:0] note;
    logic [3:0]  gate;
    int          msgs;
  } vec_t;

  vec_t vt [NV];
  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int fe_cnt = 0;

  // Counting high cycles (not edges) also catches pulses wider than one cycle.
  always @(negedge clk) begin
    if (msg_valid) mv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int          mv0, fe0;
    logic [23:0] exp_note;
    logic [3:0]  exp_gate;

    vt[0]  = '{3, 32'h903C4000, 24'h000019, 4'b0001, 1};
    vt[1]  = '{2, 32'h3E400000, 24'h00001B, 4'b0001, 1};
    vt[2]  = '{3, 32'h803C0000, 24'h00001B, 4'b0001, 1};
    vt[3]  = '{3, 32'h803E0000, 24'h00001B, 4'b0000, 1};
    vt[4]  = '{3, 32'h93247F00, 24'h04001B, 4'b1000, 1};
    vt[5]  = '{3, 32'h93240000, 24'h04001B, 4'b0000, 1};
    vt[6]  = '{3, 32'h94304000, 24'h04001B, 4'b0000, 0};
    vt[7]  = '{4, 32'h913CF850, 24'h04065B, 4'b0010, 1};
    vt[8]  = '{2, 32'h913C0000, 24'h04065B, 4'b0010, 0};
    vt[9]  = '{1, 32'h92000000, 24'h04065B, 4'b0010, 0};
    vt[10] = '{2, 32'h407F0000, 24'h05D65B, 4'b0110, 1};
    vt[11] = '{3, 32'h90234000, 24'h05D65B, 4'b0110, 0};
    vt[12] = '{3, 32'h907F4000, 24'h05D65B, 4'b0110, 0};
    vt[13] = '{3, 32'h90624000, 24'h05D67F, 4'b0111, 1};
`ifdef NOTE_CMD_ALL_OFF_EN
    vt[14] = '{3, 32'hB07B0000, 24'h05D67F, 4'b0110, 1};
    vt[15] = '{2, 32'h3C400000, 24'h05D67F, 4'b0110, 0};
    vt[16] = '{3, 32'hF03C4000, 24'h05D67F, 4'b0110, 0};
`else
    vt[14] = '{3, 32'hB07B0000, 24'h05D67F, 4'b0111, 0};
    vt[15] = '{2, 32'h3C400000, 24'h05D67F, 4'b0111, 0};
    vt[16] = '{3, 32'hF03C4000, 24'h05D67F, 4'b0111, 0};
`endif

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * Cpb) @(negedge clk);
    check("reset note", note_out, 0);
    check("reset gate", gate_out, 0);
    check("reset msg_valid pulses", mv_cnt, 0);
    check("reset frame_err pulses", fe_cnt, 0);

    for (int v = 0; v < NV; v++) begin
      mv0 = mv_cnt;
      for (int i = 0; i < vt[v].n; i++) send_byte(vt[v].bytes[31-8*i -: 8], 1'b1);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d note", v), note_out, vt[v].note);
      check($sformatf("vec%0d gate", v), gate_out, vt[v].gate);
      check($sformatf("vec%0d msg_valid pulses", v), mv_cnt - mv0, vt[v].msgs);
    end

    // Frame error on a key byte: it must be dropped so the next data byte becomes the key.
    exp_note = vt[NV-1].note;
    exp_gate = vt[NV-1].gate;
    send_byte(8'h91, 1'b1);
    fe0 = fe_cnt;
    mv0 = mv_cnt;
    send_byte(8'h3E, 1'b0);
    repeat (2) @(negedge clk);
    check("frame_err pulses", fe_cnt - fe0, 1);
    check("frame_err note", note_out, exp_note);
    check("frame_err gate", gate_out, exp_gate);
    check("frame_err msg_valid", mv_cnt - mv0, 0);
    send_byte(8'h40, 1'b1);
    send_byte(8'h7F, 1'b1);
    repeat (2) @(negedge clk);
    exp_note[11:6] = 6'd29;
    exp_gate[1]    = 1'b1;
    check("post frame_err note", note_out, exp_note);
    check("post frame_err gate", gate_out, exp_gate);
    check("post frame_err msg_valid", mv_cnt - mv0, 1);

    // Short low glitch on the idle line: no byte, no error.
    fe0 = fe_cnt;
    mv0 = mv_cnt;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12 * Cpb) @(negedge clk);
    check("glitch frame_err", fe_cnt - fe0, 0);
    check("glitch msg_valid", mv_cnt - mv0, 0);
    check("glitch note", note_out, exp_note);

    // Reset in the middle of a message and mid-byte clears everything, running status included.
    send_byte(8'h92, 1'b1);
    send_byte(8'h40, 1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("in reset note", note_out, 0);
    check("in reset gate", gate_out, 0);
    rst_n = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    mv0 = mv_cnt;
    send_byte(8'h40, 1'b1);
    send_byte(8'h7F, 1'b1);
    repeat (2) @(negedge clk);
    check("post reset data ignored note", note_out, 0);
    check("post reset data ignored gate", gate_out, 0);
    check("post reset data ignored msg", mv_cnt - mv0, 0);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (2) @(negedge clk);
    check("post reset note on note", note_out, 24'h000019);
    check("post reset note on gate", gate_out, 4'b0001);
    check("post reset note on msg", mv_cnt - mv0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_cmd_rx.md
Name: note_cmd_rx

Overview:
- Serial note-command receiver; the inbound counterpart of the hard-coded sequencer that drives note indices and enables into the base_freq_genx64 / square_gen / trigen channels.
- Receives MIDI-style bytes over a UART line (8N1).
- Parses Note On and Note Off messages and drives a 6-bit note index plus a gate per synth channel.
- Outputs connect directly to the note_in ports of the frequency generators and to the generator enables.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BAUD, 31250, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (1600 at defaults).
- NUM_CH, 4, number of synth channels decoded (message channel nibble 0..NUM_CH-1).
- NOTE_BASE, 36, MIDI key number mapped to note index 1.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- rx_in  in  1  serial input, idle high, asynchronous to clk
- note_out  out  6*NUM_CH  packed note indices; channel k occupies bits [6k+5:6k]
- gate_out  out  NUM_CH  per-channel gate (1 = note sounding)
- msg_valid  out  1  one-cycle pulse when a Note On/Off message is applied
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset (async assert, sync release): note_out=0, gate_out=0, msg_valid=0, frame_err=0; UART FSM in IDLE; parser in WAIT_STATUS with running status cleared.
- Input sync: rx_in passes through a 2-flop synchronizer before any use.
- UART states:
  - IDLE: falling edge seen -> START.
  - START: at CLKS_PER_BIT/2, line still low -> DATA; line high -> IDLE (glitch, no error).
  - DATA: 8 bits sampled every CLKS_PER_BIT, LSB first -> STOP.
  - STOP: sample at CLKS_PER_BIT. High -> byte strobe for 1 cycle. Low -> frame_err pulse, byte discarded, wait for line high, then IDLE.
- Parser (runs on each byte strobe):
  - 0xF8-0xFF (real-time): ignored; parser state untouched.
  - Other status byte (bit7=1): aborts any partial message.
    - 0x9n / 0x8n with n<NUM_CH: store as running status -> WAIT_KEY.
    - Anything else (incl. n>=NUM_CH): clear running status -> WAIT_STATUS; following data bytes are ignored.
  - Data byte in WAIT_STATUS with valid running status: treated as key -> WAIT_VEL.
  - WAIT_KEY: latch key -> WAIT_VEL.
  - WAIT_VEL: apply the message -> WAIT_KEY (running status retained).
- Key mapping: idx = key - NOTE_BASE + 1. Key < NOTE_BASE or idx > 63: message dropped silently, no msg_valid.
- Apply: registered one cycle after the velocity byte strobe; msg_valid pulses in the same cycle.
  - Note On, vel>0: note_out[n]=idx, gate_out[n]=1. Overwrites any sounding note (last-note priority).
  - Note Off, or Note On with vel=0: gate_out[n]=0 only if idx equals note_out[n]; note_out[n] holds its value. Non-matching key: no change, msg_valid still pulses.
- Untouched channels hold state indefinitely.
- Reset mid-byte or mid-message: all state cleared. The next valid byte must be a status byte.

Optional Feature:
- Macro: NOTE_CMD_ALL_OFF_EN.
- Defined: 0xBn (n<NUM_CH) is accepted as a running status. Controller 123 with any value clears gate_out[n], note_out unchanged, msg_valid pulses. Other controllers are ignored.
- Undefined: 0xBn is treated as an unsupported status; its data bytes are ignored.

Test Plan:
- Reset with rx_in idle high -> all outputs 0; no byte strobe for 10 bit-times.
- Send 0x90,0x3C,0x40 -> one cycle after the velocity stop bit: note_out[5:0]=25, gate_out=0001, one msg_valid pulse.
- Then send 0x3E,0x40 (running status), then 0x80,0x3C,0x00 -> note_out ch0=27, gate stays 1 (key mismatch). Then 0x80,0x3E,0x00 -> gate_out[0]=0, note_out ch0 stays 27.
- Send 0x93,0x24,0x7F then 0x93,0x24,0x00 -> ch3 note=1, gate 1, then gate 0. Send 0x94,0x30,0x40 (n=NUM_CH) -> no change, no msg_valid.
- Send 0x91,0x3C,0xF8,0x50 -> real-time byte ignored; ch1 note=25, gate 1. Send 0x91,0x3C then 0x92 -> ch1 unchanged; parser waits for ch2 key.
- Send a byte with stop bit forced low -> frame_err one-cycle pulse, byte dropped, outputs unchanged. Send 0x90,0x23,0x40 (key below NOTE_BASE) -> no msg_valid.
